fifo_wr_arbiter: RTL and testbench

Two-requester write-port arbiter for the shared edge-strobed transmit FIFO. It accepts level requests from two producers, such as the UART receive path and the configuration/command engine. It grants one requester at a time and latches its data word. It then drives the FIFO's data bus and a clean, clock-aligned rising edge on the FIFO write strobe. The arbiter sits between the producers and the FIFO. It is the only block allowed to toggle the FIFO write instruction.

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle for the transmit FIFO write arbiter.
// master: the arbiter; slave: producers plus the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             ack0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             ack1;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_wr;
    logic             busy;

    modport master (
        input  req0, data0, req1, data1, fifo_full,
        output ack0, ack1, fifo_data, fifo_wr, busy
    );

    modport slave (
        output req0, data0, req1, data1, fifo_full,
        input  ack0, ack1, fifo_data, fifo_wr, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter producing a clean registered strobe for the edge-strobed TX FIFO.
// Define WR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned CNT_W = $clog2(STROBE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic             fifo_wr_q, fifo_wr_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic             grant_q, grant_d;
    logic             win_c;

`ifdef WR_ARB_FIXED_PRIO_EN
    // Requester 1 only wins when requester 0 is idle
    assign win_c = ~bus.req0;
`else
    logic             last_q, last_d;

    // Contention goes to whoever did not win last; a lone request always wins
    assign win_c = (bus.req0 && bus.req1) ? ~last_q : ~bus.req0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fifo_data_d = fifo_data_q;
        fifo_wr_d   = fifo_wr_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        busy_d      = busy_q;
        grant_d     = grant_q;
`ifndef WR_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.fifo_full && (bus.req0 || bus.req1)) begin
                    state_d     = SETUP;
                    grant_d     = win_c;
                    fifo_data_d = win_c ? bus.data1 : bus.data0;
                    busy_d      = 1'b1;
                end
            end
            SETUP: begin
                state_d   = STROBE;
                fifo_wr_d = 1'b1;
                cnt_d     = CNT_W'(STROBE_CYCLES - 1);
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d   = RELEASE;
                    fifo_wr_d = 1'b0;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
`ifndef WR_ARB_FIXED_PRIO_EN
                last_d  = grant_q;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Async reset drops the strobe immediately, cutting any write in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fifo_data_q <= '0;
            fifo_wr_q   <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            grant_q     <= 1'b0;
`ifndef WR_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_wr_q   <= fifo_wr_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
`ifndef WR_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.fifo_data = fifo_data_q;
    assign bus.fifo_wr   = fifo_wr_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: three instances with STROBE_CYCLES = 1, 3 and 4.
module tb_fifo_wr_arbiter;
    localparam int unsigned WIDTH = 8;

    logic clk     = 1'b0;
    logic rst_n_a = 1'b1;
    logic rst_n_b = 1'b1;
    logic rst_n_c = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic prev_c = 1'b0;
    int   acks0_a = 0;
    int   acks1_a = 0;
    int   acks_b  = 0;
    int   acks_c  = 0;
    logic [WIDTH-1:0] words_a[$];
    logic [WIDTH-1:0] words_b[$];
    logic [WIDTH-1:0] words_c[$];
    int   rise_a[$];
    int   rise_c[$];

    fifo_wr_arbiter_if #(.WIDTH(WIDTH)) bus_a ();
    fifo_wr_arbiter_if #(.WIDTH(WIDTH)) bus_b ();
    fifo_wr_arbiter_if #(.WIDTH(WIDTH)) bus_c ();

    fifo_wr_arbiter #(.WIDTH(WIDTH), .STROBE_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a.master));
    fifo_wr_arbiter #(.WIDTH(WIDTH), .STROBE_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b.master));
    fifo_wr_arbiter #(.WIDTH(WIDTH), .STROBE_CYCLES(4)) dut_c (.clk(clk), .rst_n(rst_n_c), .bus(bus_c.master));

    always #5 clk = ~clk;

    // FIFO-side model: capture the word on each rising write strobe, count ack pulses
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.fifo_wr && !prev_a) begin
            words_a.push_back(bus_a.fifo_data);
            rise_a.push_back(cyc);
        end
        if (bus_b.fifo_wr && !prev_b) words_b.push_back(bus_b.fifo_data);
        if (bus_c.fifo_wr && !prev_c) begin
            words_c.push_back(bus_c.fifo_data);
            rise_c.push_back(cyc);
        end
        prev_a <= bus_a.fifo_wr;
        prev_b <= bus_b.fifo_wr;
        prev_c <= bus_c.fifo_wr;
        if (bus_a.ack0) acks0_a <= acks0_a + 1;
        if (bus_a.ack1) acks1_a <= acks1_a + 1;
        if (bus_b.ack0 || bus_b.ack1) acks_b <= acks_b + 1;
        if (bus_c.ack0 || bus_c.ack1) acks_c <= acks_c + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.data0 = '0; bus_a.data1 = '0; bus_a.fifo_full = 1'b0;
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.data0 = '0; bus_b.data1 = '0; bus_b.fifo_full = 1'b0;
        bus_c.req0 = 1'b0; bus_c.req1 = 1'b0; bus_c.data0 = '0; bus_c.data1 = '0; bus_c.fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        #2;
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        #1;
        checks++;
        if ({bus_a.fifo_wr, bus_a.ack0, bus_a.ack1, bus_a.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: wr/ack0/ack1/busy=%b expected 0000",
                     {bus_a.fifo_wr, bus_a.ack0, bus_a.ack1, bus_a.busy});
        end
        checks++;
        if (bus_a.fifo_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: fifo_data=%h expected 00", bus_a.fifo_data);
        end
        repeat (2) tick();
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus_a.busy, bus_b.busy, bus_c.busy, bus_a.fifo_wr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: busy_a/b/c,wr_a=%b expected 0000",
                     {bus_a.busy, bus_b.busy, bus_c.busy, bus_a.fifo_wr});
        end
    endtask

    task automatic test_single();
        int base;
        int a0;
        base = words_a.size();
        a0   = acks0_a;
        bus_a.req0  = 1'b1;
        bus_a.data0 = 8'hA5;
        tick();
        checks++;
        if ({bus_a.busy, bus_a.fifo_wr} !== 2'b10 || bus_a.fifo_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_setup: busy,wr=%b data=%h expected 10 a5",
                     {bus_a.busy, bus_a.fifo_wr}, bus_a.fifo_data);
        end
        tick();
        checks++;
        if ({bus_a.fifo_wr, bus_a.ack0} !== 2'b10) begin
            errors++;
            $display("FAIL single_strobe: wr,ack0=%b expected 10", {bus_a.fifo_wr, bus_a.ack0});
        end
        tick();
        checks++;
        if ({bus_a.fifo_wr, bus_a.ack0, bus_a.busy} !== 3'b011) begin
            errors++;
            $display("FAIL single_release: wr,ack0,busy=%b expected 011",
                     {bus_a.fifo_wr, bus_a.ack0, bus_a.busy});
        end
        bus_a.req0 = 1'b0;
        tick();
        checks++;
        if ({bus_a.ack0, bus_a.busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: ack0,busy=%b expected 00", {bus_a.ack0, bus_a.busy});
        end
        tick();
        checks++;
        if (words_a.size() !== base + 1 || acks0_a !== a0 + 1) begin
            errors++;
            $display("FAIL single_count: writes=%0d acks=%0d expected 1 1",
                     words_a.size() - base, acks0_a - a0);
        end else begin
            checks++;
            if (words_a[base] !== 8'hA5) begin
                errors++;
                $display("FAIL single_word: written=%h expected a5", words_a[base]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] w0 [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        logic [WIDTH-1:0] w1 [4] = '{8'h20, 8'h21, 8'h22, 8'h23};
`ifdef WR_ARB_FIXED_PRIO_EN
        logic [WIDTH-1:0] exp [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
`else
        logic [WIDTH-1:0] exp [8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
`endif
        int base;
        int rbase;
        int i0 = 0;
        int i1 = 0;
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        tick();
        base  = words_a.size();
        rbase = rise_a.size();
        bus_a.req0 = 1'b1; bus_a.data0 = w0[0];
        bus_a.req1 = 1'b1; bus_a.data1 = w1[0];
        for (int n = 0; n < 80 && (i0 < 4 || i1 < 4); n++) begin
            tick();
            if (bus_a.ack0) begin
                i0++;
                if (i0 < 4) bus_a.data0 = w0[i0]; else bus_a.req0 = 1'b0;
            end
            if (bus_a.ack1) begin
                i1++;
                if (i1 < 4) bus_a.data1 = w1[i1]; else bus_a.req1 = 1'b0;
            end
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        checks++;
        if (i0 != 4 || i1 != 4) begin
            errors++;
            $display("FAIL rr_acks: acks0=%0d acks1=%0d expected 4 4 within budget", i0, i1);
        end
        repeat (2) tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (words_a.size() <= base + k) begin
                errors++;
                $display("FAIL rr_word%0d: missing write expected %h", k, exp[k]);
            end else if (words_a[base + k] !== exp[k]) begin
                errors++;
                $display("FAIL rr_word%0d: written=%h expected %h", k, words_a[base + k], exp[k]);
            end
        end
        checks++;
        if (rise_a.size() < rbase + 2) begin
            errors++;
            $display("FAIL rr_gap: only %0d strobes expected >=2", rise_a.size() - rbase);
        end else if (rise_a[rbase + 1] - rise_a[rbase] !== 4) begin
            errors++;
            $display("FAIL rr_gap: strobe spacing=%0d expected 4", rise_a[rbase + 1] - rise_a[rbase]);
        end
    endtask

    task automatic test_full();
        int   base;
        int   a1;
        logic busy_seen = 1'b0;
        int   ack_at = 0;
        base = words_a.size();
        a1   = acks1_a;
        bus_a.fifo_full = 1'b1;
        bus_a.req1      = 1'b1;
        bus_a.data1     = 8'h5C;
        repeat (20) begin
            tick();
            if (bus_a.busy) busy_seen = 1'b1;
        end
        checks++;
        if (words_a.size() !== base || acks1_a !== a1 || busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: writes=%0d acks1=%0d busy_seen=%b expected 0 0 0",
                     words_a.size() - base, acks1_a - a1, busy_seen);
        end
        bus_a.fifo_full = 1'b0;
        for (int k = 1; k <= 8 && ack_at == 0; k++) begin
            tick();
            if (bus_a.ack1) ack_at = k;
        end
        bus_a.req1 = 1'b0;
        checks++;
        if (ack_at !== 3) begin
            errors++;
            $display("FAIL full_release: ack1 after %0d cycles expected 3", ack_at);
        end
        tick();
        checks++;
        if (words_a.size() !== base + 1) begin
            errors++;
            $display("FAIL full_word: writes=%0d expected 1", words_a.size() - base);
        end else if (words_a[base] !== 8'h5C) begin
            errors++;
            $display("FAIL full_word: written=%h expected 5c", words_a[base]);
        end
    endtask

    task automatic test_drop();
        int base;
        int a0;
        base = words_a.size();
        a0   = acks0_a;
        bus_a.req0  = 1'b1;
        bus_a.data0 = 8'h3C;
        tick();
        bus_a.req0  = 1'b0;
        bus_a.data0 = 8'hFF;
        checks++;
        if (bus_a.fifo_data !== 8'h3C) begin
            errors++;
            $display("FAIL drop_latch: fifo_data=%h expected 3c", bus_a.fifo_data);
        end
        repeat (8) tick();
        checks++;
        if (words_a.size() !== base + 1 || acks0_a !== a0 + 1) begin
            errors++;
            $display("FAIL drop_count: writes=%0d acks0=%0d expected 1 1",
                     words_a.size() - base, acks0_a - a0);
        end else begin
            checks++;
            if (words_a[base] !== 8'h3C) begin
                errors++;
                $display("FAIL drop_word: written=%h expected 3c", words_a[base]);
            end
        end
    endtask

    task automatic test_reset_strobe();
        int a;
        int got = 0;
        bus_b.req0  = 1'b1;
        bus_b.data0 = 8'h77;
        tick();
        tick();
        checks++;
        if (bus_b.fifo_wr !== 1'b1) begin
            errors++;
            $display("FAIL rst_strobe_pre: fifo_wr=%b expected 1", bus_b.fifo_wr);
        end
        tick();
        a = acks_b;
        #2;
        rst_n_b    = 1'b0;
        bus_b.req0 = 1'b0;
        #1;
        checks++;
        if ({bus_b.fifo_wr, bus_b.ack0, bus_b.ack1, bus_b.busy} !== 4'b0000 || bus_b.fifo_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_strobe_async: wr/ack0/ack1/busy=%b data=%h expected 0000 00",
                     {bus_b.fifo_wr, bus_b.ack0, bus_b.ack1, bus_b.busy}, bus_b.fifo_data);
        end
        repeat (2) tick();
        rst_n_b = 1'b1;
        tick();
        checks++;
        if (acks_b !== a) begin
            errors++;
            $display("FAIL rst_strobe_noack: acks=%0d expected %0d", acks_b, a);
        end
        bus_b.req0 = 1'b1; bus_b.data0 = 8'h41;
        bus_b.req1 = 1'b1; bus_b.data1 = 8'h42;
        for (int n = 0; n < 40 && got < 2; n++) begin
            tick();
            if (bus_b.ack0) begin bus_b.req0 = 1'b0; got++; end
            if (bus_b.ack1) begin bus_b.req1 = 1'b0; got++; end
        end
        bus_b.req0 = 1'b0;
        bus_b.req1 = 1'b0;
        tick();
        checks++;
        if (words_b.size() !== 3) begin
            errors++;
            $display("FAIL rst_strobe_writes: strobes=%0d expected 3", words_b.size());
        end else begin
            checks++;
            if (words_b[1] !== 8'h41 || words_b[2] !== 8'h42) begin
                errors++;
                $display("FAIL rst_strobe_order: written=%h,%h expected 41,42", words_b[1], words_b[2]);
            end
        end
    endtask

    task automatic test_strobe4();
        logic [WIDTH-1:0] w [2] = '{8'h99, 8'h9A};
        int high   = 0;
        int ack_at = 0;
        int i      = 0;
        int rbase;
        rbase = rise_c.size();
        bus_c.req1  = 1'b1;
        bus_c.data1 = w[0];
        for (int n = 1; n <= 30 && i < 2; n++) begin
            tick();
            if (bus_c.fifo_wr) high++;
            if (bus_c.ack1) begin
                if (i == 0) ack_at = n;
                i++;
                if (i < 2) bus_c.data1 = w[i]; else bus_c.req1 = 1'b0;
            end
        end
        bus_c.req1 = 1'b0;
        checks++;
        if (ack_at !== 6) begin
            errors++;
            $display("FAIL s4_latency: ack1 at cycle %0d expected 6", ack_at);
        end
        checks++;
        if (high !== 8) begin
            errors++;
            $display("FAIL s4_high: fifo_wr high %0d cycles expected 8", high);
        end
        tick();
        checks++;
        if (bus_c.busy !== 1'b0) begin
            errors++;
            $display("FAIL s4_idle: busy=%b expected 0", bus_c.busy);
        end
        checks++;
        if (rise_c.size() !== rbase + 2) begin
            errors++;
            $display("FAIL s4_gap: strobes=%0d expected 2", rise_c.size() - rbase);
        end else if (rise_c[rbase + 1] - rise_c[rbase] !== 7 || words_c[1] !== 8'h9A) begin
            errors++;
            $display("FAIL s4_gap: spacing=%0d word=%h expected 7 9a",
                     rise_c[rbase + 1] - rise_c[rbase], words_c[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_drop();
        test_reset_strobe();
        test_strobe4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
